uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised, buffered UART transmitter. It replaces the fixed 8N1 transmitter in the communication modules, adding the following:
- configurable data width, parity and stop bits;
- a runtime baud divisor;
- an internal FIFO, so the sudoku front end can queue several characters without polling `busy`.

It sits between the board/UI logic and the serial TX pin.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9.
- `PARITY`, default 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.
- `DIV_W`, default 16: width of `baud_div`.
- `FIFO_DEPTH`, default 8: FIFO entries. Must be a power of two, at least 2.

Ports:
- `clk` — input, 1 — clock.
- `rst` — input, 1 — reset, asynchronous, active-high.
- `baud_div` — input, DIV_W — clocks per bit. Values below 2 are treated as 2.
- `wr_data` — input, DATA_BITS — word to queue.
- `wr_valid` — input, 1 — write request.
- `wr_ready` — output, 1 — FIFO not full.
- `fifo_count` — output, $clog2(FIFO_DEPTH)+1 — words currently queued.
- `tx` — output, 1 — serial line, idle high.
- `busy` — output, 1 — high when a frame is in progress or the FIFO is non-empty.

## Operation
- **Write:** a word is accepted on any rising edge where `wr_valid && wr_ready`.
  - A write while full is dropped silently; `fifo_count` is unchanged.
- **Frame format:** start bit (0), data bits LSB first, optional parity bit, then STOP_BITS stop bits (1).
- **Parity:**
  - Even: parity bit = XOR of the data bits.
  - Odd: parity bit = XNOR of the data bits.
- **FSM states:** IDLE, START, DATA, PAR, STOP.
  - IDLE → START when `fifo_count != 0`. The head word is popped into the shift register and `baud_div` is latched, in the same cycle.
  - START → DATA after one bit period.
  - DATA → PAR (if PARITY != 0) or STOP after DATA_BITS bit periods.
  - PAR → STOP after one bit period.
  - STOP → START after STOP_BITS bit periods if the FIFO is non-empty, with the pop happening in that cycle. Otherwise STOP → IDLE.
- **Divisor latching:** the latched divisor holds for the whole frame. Changes to `baud_div` mid-frame affect only the next frame.
- **Simultaneous write and pop:** `fifo_count` stays the same, and both operations take effect.
- **Write to an empty FIFO in IDLE:** the word is popped on the next edge.
- **Reset values:**
  - `tx` = 1, `busy` = 0, `wr_ready` = 1, `fifo_count` = 0, state = IDLE.
  - FIFO pointers are cleared, so queued words are discarded.
- **Reset mid-frame:** `tx` returns high immediately (asynchronously) and the partial frame is abandoned.

## Timing
- **Bit period:** each bit is held for exactly D clocks, where D = max(latched `baud_div`, 2).
- **Frame length:** D × (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) clocks.
- **Start latency:** with a pop on edge N, `tx` falls on edge N+1.
  - Write-to-start-bit latency from idle with an empty FIFO is therefore 2 edges.
- **Back-to-back frames:** no idle gap. The next start bit begins on the edge right after the last stop-bit clock.
- **`tx` is registered:** no combinational path from any input to `tx`.
- **`wr_ready` and `fifo_count`:** both are registered state. They update on the edge where the write or pop occurs.
- **`busy`:** falls on the same edge that `tx` enters IDLE with the FIFO empty.

## Structure
- **Package `uart_pkg`** holds:
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - the FSM state encoding;
  - a frame-length helper function.
- **Sub-module `uart_fifo`:** a synchronous FIFO, parametrised on width and depth. Full/empty are derived from pointers with an extra wrap bit. It exposes push, pop, head data and count.
- **Top level** contains the FSM, the baud counter, the bit counter and the shift register.

## Test plan
- **8N1, single word:** DATA_BITS=8, PARITY=0, STOP_BITS=1, `baud_div`=4. Write 0xA5.
  - `tx` must be 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks (40 clocks total).
  - `busy` then drops and `tx` stays 1.
- **Parity modes:** `baud_div`=4.
  - Even parity with 0x03: parity bit must be 0.
  - Odd parity with 0x03: parity bit must be 1.
  - DATA_BITS=7 with odd parity and 0x01: parity bit must be 0; frame is 40 clocks with STOP_BITS=1.
- **Two stop bits:** STOP_BITS=2, `baud_div`=3. Write 0x00.
  - Nine low bits (start + 8 data) must be followed by 6 clocks high.
  - A second queued word must start on the very next clock.
- **FIFO full:** FIFO_DEPTH=8. Drive 10 back-to-back writes from IDLE.
  - Word 0 is popped, and words 1–8 fill the FIFO.
  - `wr_ready` must be low after word 8, and word 9 is dropped.
  - Exactly 9 frames must appear on `tx`, in write order.
- **Divisor change mid-frame:** change `baud_div` from 4 to 8 during a frame.
  - The current frame keeps 4 clocks per bit; the next frame uses 8.
  - `baud_div`=0 must behave exactly like 2.
- **Reset mid-frame:** assert `rst` in the middle of the third data bit, with 3 words queued.
  - `tx` must go to 1 and `fifo_count` to 0 without waiting for a clock edge.
  - No frame may follow the release of reset.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the buffered UART transmitter: parity modes,
// FSM state encoding and a frame-length helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    // Bits per frame: start + data + optional parity + stop bits.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head word is visible combinationally.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer update; pushes while full and pops while empty are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write, no reset needed since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO, frame FSM, baud/bit counters, registered tx.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx,
    output logic                          busy
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    logic [2:0]           state;
    logic [DIV_W-1:0]     baud_cnt;
    logic [DIV_W-1:0]     div_q;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_q;
    logic                 frame_active;
    logic                 tx_next;

    logic [DATA_BITS-1:0] head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 bit_done;
    logic                 par_calc;
    logic [DIV_W-1:0]     eff_div;

    assign push     = wr_valid && !full;
    assign wr_ready = !full;
    assign bit_done = (baud_cnt == div_q - DIV_W'(1));
    assign pop      = !empty && ((state == S_IDLE) ||
                                 ((state == S_STOP) && bit_done && (bit_cnt == LAST_STOP)));
    assign par_calc = (PARITY == PAR_EVEN) ? ^head : ~^head;
    assign eff_div  = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
    assign busy     = frame_active || !empty;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_data),
        .head    (head),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty)
    );

    // Line level for the bit the FSM is currently timing; registered one clock later.
    always_comb begin
        tx_next = 1'b1;
        case (state)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = shift[0];
            S_PAR:   tx_next = par_q;
            default: tx_next = 1'b1;
        endcase
    end

    // Frame FSM; tx lags state by one clock so a pop on edge N drives the start bit from N+1,
    // and frame_active lags the same way so busy drops together with the last stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            baud_cnt     <= '0;
            div_q        <= DIV_W'(2);
            bit_cnt      <= '0;
            shift        <= '0;
            par_q        <= 1'b0;
            tx           <= 1'b1;
            frame_active <= 1'b0;
        end else begin
            tx           <= tx_next;
            frame_active <= (state != S_IDLE) || pop;
            if (pop) begin
                state    <= S_START;
                shift    <= head;
                par_q    <= par_calc;
                div_q    <= eff_div;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if (state != S_IDLE) begin
                baud_cnt <= bit_done ? '0 : baud_cnt + DIV_W'(1);
                if (bit_done) begin
                    case (state)
                        S_START: begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                        S_DATA: begin
                            shift <= shift >> 1;
                            if (bit_cnt == LAST_DATA) begin
                                state   <= (PARITY != PAR_NONE) ? S_PAR : S_STOP;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                        S_PAR: begin
                            state   <= S_STOP;
                            bit_cnt <= '0;
                        end
                        S_STOP: begin
                            if (bit_cnt == LAST_STOP)
                                state <= S_IDLE;
                            else
                                bit_cnt <= bit_cnt + 4'd1;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo across 8N1, 8E1, 7O1 and 8N2 instances.
module tb_uart_tx_fifo;

    logic        clk;
    logic        rst;
    logic [15:0] baud;
    logic [3:0]  wv;
    logic [3:0]  txs;
    logic [3:0]  rdy;
    logic [3:0]  bsy;
    logic [3:0]  cnt [4];
    logic [7:0]  wd0;
    logic [7:0]  wd1;
    logic [6:0]  wd2;
    logic [7:0]  wd3;

    int n_cmp;
    int n_bad;

    uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16), .FIFO_DEPTH(8)) u_8n1 (
        .clk(clk), .rst(rst), .baud_div(baud), .wr_data(wd0), .wr_valid(wv[0]),
        .wr_ready(rdy[0]), .fifo_count(cnt[0]), .tx(txs[0]), .busy(bsy[0]));

    uart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DIV_W(16), .FIFO_DEPTH(8)) u_8e1 (
        .clk(clk), .rst(rst), .baud_div(baud), .wr_data(wd1), .wr_valid(wv[1]),
        .wr_ready(rdy[1]), .fifo_count(cnt[1]), .tx(txs[1]), .busy(bsy[1]));

    uart_tx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .DIV_W(16), .FIFO_DEPTH(8)) u_7o1 (
        .clk(clk), .rst(rst), .baud_div(baud), .wr_data(wd2), .wr_valid(wv[2]),
        .wr_ready(rdy[2]), .fifo_count(cnt[2]), .tx(txs[2]), .busy(bsy[2]));

    uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .DIV_W(16), .FIFO_DEPTH(8)) u_8n2 (
        .clk(clk), .rst(rst), .baud_div(baud), .wr_data(wd3), .wr_valid(wv[3]),
        .wr_ready(rdy[3]), .fifo_count(cnt[3]), .tx(txs[3]), .busy(bsy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // One write on the next edge; returns 1 time unit after that edge.
    task automatic push_word(input int idx, input logic [7:0] d);
        case (idx)
            0: wd0 = d;
            1: wd1 = d;
            2: wd2 = d[6:0];
            default: wd3 = d;
        endcase
        wv[idx] = 1'b1;
        @(posedge clk); #1;
        wv[idx] = 1'b0;
    endtask

    // Checks tx every clock for frame clocks [from, to); bits[0] is the start bit.
    task automatic check_span(input int idx, input logic [15:0] bits, input int d,
                              input int from, input int to, input string tag);
        for (int k = from; k < to; k++) begin
            check($sformatf("%s clk%0d", tag, k), 32'(txs[idx]), 32'(bits[k / d]));
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [15:0] f8n1(input logic [7:0] d);
        return 16'({1'b1, d, 1'b0});
    endfunction

    initial begin
        logic [15:0] f0;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        wv    = '0;
        baud  = 16'd4;
        wd0 = '0; wd1 = '0; wd2 = '0; wd3 = '0;

        // Reset state on every instance
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst tx%0d", i),    32'(txs[i]), 32'd1);
            check($sformatf("rst busy%0d", i),  32'(bsy[i]), 32'd0);
            check($sformatf("rst ready%0d", i), 32'(rdy[i]), 32'd1);
            check($sformatf("rst cnt%0d", i),   32'(cnt[i]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // 8N1 single word 0xA5 at baud 4
        push_word(0, 8'hA5);
        check("a5 cnt after write", 32'(cnt[0]), 32'd1);
        check("a5 busy after write", 32'(bsy[0]), 32'd1);
        @(posedge clk); #1;
        check("a5 cnt after pop", 32'(cnt[0]), 32'd0);
        check("a5 busy after pop", 32'(bsy[0]), 32'd1);
        check("a5 tx before start", 32'(txs[0]), 32'd1);
        @(posedge clk); #1;
        check_span(0, 16'b11_0100_1010, 4, 0, 40, "a5");
        check("a5 busy end", 32'(bsy[0]), 32'd0);
        for (int k = 0; k < 6; k++) begin
            check("a5 idle tx", 32'(txs[0]), 32'd1);
            @(posedge clk); #1;
        end

        // Even parity, 0x03 -> parity 0
        push_word(1, 8'h03);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_span(1, 16'b100_0000_0110, 4, 0, 44, "8e1 03");
        check("8e1 busy end", 32'(bsy[1]), 32'd0);

        // 7 data bits, odd parity: 0x01 -> parity 0, 0x03 -> parity 1
        push_word(2, 8'h01);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_span(2, 16'b10_0000_0010, 4, 0, 40, "7o1 01");
        check("7o1 tx idle", 32'(txs[2]), 32'd1);
        check("7o1 busy end", 32'(bsy[2]), 32'd0);
        push_word(2, 8'h03);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_span(2, 16'b11_0000_0110, 4, 0, 40, "7o1 03");

        // Two stop bits at baud 3, second word back-to-back
        baud = 16'd3;
        push_word(3, 8'h00);
        push_word(3, 8'hFF);
        @(posedge clk); #1;
        check_span(3, 16'b110_0000_0000, 3, 0, 33, "8n2 00");
        check_span(3, 16'b111_1111_1110, 3, 0, 33, "8n2 ff");
        check("8n2 tx idle", 32'(txs[3]), 32'd1);
        check("8n2 busy end", 32'(bsy[3]), 32'd0);

        // FIFO full: 10 back-to-back writes, word 9 dropped
        baud = 16'd4;
        f0 = f8n1(8'h30);
        for (int i = 0; i < 10; i++) begin
            push_word(0, 8'(8'h30 + i));
            check($sformatf("full cnt w%0d", i), 32'(cnt[0]),
                  (i == 0) ? 32'd1 : ((i <= 8) ? 32'(i) : 32'd8));
            check($sformatf("full ready w%0d", i), 32'(rdy[0]), (i >= 8) ? 32'd0 : 32'd1);
            if (i >= 2)
                check($sformatf("full w0 clk%0d", i - 2), 32'(txs[0]), 32'(f0[(i - 2) / 4]));
            else
                check($sformatf("full pre tx%0d", i), 32'(txs[0]), 32'd1);
        end
        @(posedge clk); #1;
        check_span(0, f0, 4, 8, 40, "full w0");
        for (int k = 1; k <= 8; k++)
            check_span(0, f8n1(8'(8'h30 + k)), 4, 0, 40, $sformatf("full w%0d", k));
        check("full busy end", 32'(bsy[0]), 32'd0);
        check("full cnt end", 32'(cnt[0]), 32'd0);
        for (int k = 0; k < 45; k++) begin
            check("full no 10th frame", 32'(txs[0]), 32'd1);
            @(posedge clk); #1;
        end

        // Divisor change mid-frame: current frame stays at 4, next uses 8
        push_word(0, 8'h5A);
        push_word(0, 8'hC3);
        @(posedge clk); #1;
        check_span(0, f8n1(8'h5A), 4, 0, 10, "div 5a");
        baud = 16'd8;
        check_span(0, f8n1(8'h5A), 4, 10, 40, "div 5a");
        check_span(0, f8n1(8'hC3), 8, 0, 80, "div c3");
        check("div busy end", 32'(bsy[0]), 32'd0);

        // Divisors 0 and 1 clamp to 2
        baud = 16'd0;
        push_word(0, 8'hA5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_span(0, f8n1(8'hA5), 2, 0, 20, "div0");
        check("div0 tx idle", 32'(txs[0]), 32'd1);
        baud = 16'd1;
        push_word(0, 8'h3C);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_span(0, f8n1(8'h3C), 2, 0, 20, "div1");
        check("div1 busy end", 32'(bsy[0]), 32'd0);

        // Reset in the third data bit with 3 words queued
        baud = 16'd4;
        for (int i = 0; i < 4; i++)
            push_word(0, 8'h00);
        check("mid cnt queued", 32'(cnt[0]), 32'd3);
        repeat (12) @(posedge clk);
        #2;
        check("mid tx data bit2", 32'(txs[0]), 32'd0);
        check("mid busy", 32'(bsy[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("mid rst tx async", 32'(txs[0]), 32'd1);
        check("mid rst cnt async", 32'(cnt[0]), 32'd0);
        check("mid rst ready async", 32'(rdy[0]), 32'd1);
        check("mid rst busy async", 32'(bsy[0]), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            check("post rst tx idle", 32'(txs[0]), 32'd1);
            @(posedge clk); #1;
        end
        check("post rst busy", 32'(bsy[0]), 32'd0);
        check("post rst cnt", 32'(cnt[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
